// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC register, redirect select, IF/ID register
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_out,
  input  logic [31:0] im_inst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic [31:0] id_pc_plus4,
  output logic [31:0] ifid_inst,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        addr_err
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        addr_err_q, addr_err_d;

  logic [31:0] pc_plus4;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] jr_target_al;
  logic [31:0] redirect_target;
  logic        redirect;
  logic        jr_misaligned;

  // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 becomes zero with no flag.
  assign pc_plus4      = pc_q + 32'd4;
  assign br_target     = id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
  assign jmp_target    = {id_pc_plus4[31:28], jmp_index, 2'b00};
  assign jr_target_al  = {jr_target[31:2], 2'b00};
  assign jr_misaligned = jr_target[1:0] != 2'b00;
  assign redirect      = jr | jmp | br_taken;

  always_comb begin
    redirect_target = br_target;
    if (jr) begin
      redirect_target = jr_target_al;
    end else if (jmp) begin
      redirect_target = jmp_target;
    end
  end

  // A redirect seen during a stall is dropped; ID re-issues it once the stall clears.
  always_comb begin
    pc_d            = pc_q;
    ifid_inst_d     = ifid_inst_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    ifid_valid_d    = ifid_valid_q;
    addr_err_d      = 1'b0;
    if (stall) begin
      addr_err_d = 1'b0;
    end else if (redirect) begin
      pc_d            = redirect_target;
      ifid_inst_d     = NOP_INST;
      ifid_pc_plus4_d = 32'd0;
      ifid_valid_d    = 1'b0;
      addr_err_d      = jr & jr_misaligned;
    end else begin
      pc_d            = pc_plus4;
      ifid_inst_d     = im_inst;
      ifid_pc_plus4_d = pc_plus4;
      ifid_valid_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= RESET_PC;
      ifid_inst_q     <= NOP_INST;
      ifid_pc_plus4_q <= 32'd0;
      ifid_valid_q    <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      ifid_inst_q     <= ifid_inst_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      ifid_valid_q    <= ifid_valid_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign pc_out        = pc_q;
  assign ifid_inst     = ifid_inst_q;
  assign ifid_pc_plus4 = ifid_pc_plus4_q;
  assign ifid_valid    = ifid_valid_q;
  assign addr_err      = addr_err_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic [31:0] pc_out;
  logic [31:0] im_inst;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_offset;
  logic        jmp;
  logic [25:0] jmp_index;
  logic        jr;
  logic [31:0] jr_target;
  logic [31:0] id_pc_plus4;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
  logic        addr_err;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        br;
    logic [15:0] off;
    logic        jmp;
    logic [25:0] idx;
    logic        jr;
    logic [31:0] jrt;
    logic [31:0] idpc4;
    logic [31:0] im;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic [31:0] e_p4;
    logic        e_v;
    logic        e_ae;
  } vec_t;

  vec_t vecs[$];

  if_stage dut (
    .clk(clk), .rst(rst), .pc_out(pc_out), .im_inst(im_inst), .stall(stall),
    .br_taken(br_taken), .br_offset(br_offset), .jmp(jmp), .jmp_index(jmp_index),
    .jr(jr), .jr_target(jr_target), .id_pc_plus4(id_pc_plus4), .ifid_inst(ifid_inst),
    .ifid_pc_plus4(ifid_pc_plus4), .ifid_valid(ifid_valid), .addr_err(addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic b, input logic [15:0] o,
                     input logic j, input logic [25:0] ix, input logic jrr, input logic [31:0] jt,
                     input logic [31:0] ip, input logic [31:0] im,
                     input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4,
                     input logic ev, input logic eae);
    vec_t v;
    v = '{r, s, b, o, j, ix, jrr, jt, ip, im, epc, ei, ep4, ev, eae};
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    rst = 1'b0; stall = 1'b0; br_taken = 1'b0; br_offset = 16'h0; jmp = 1'b0;
    jmp_index = 26'h0; jr = 1'b0; jr_target = 32'h0; id_pc_plus4 = 32'h0; im_inst = 32'h0;
  endtask

  task automatic check_state(input string tag, input logic [31:0] epc, input logic [31:0] ei,
                             input logic [31:0] ep4, input logic ev, input logic eae);
    check({tag, ".pc_out"}, pc_out, epc);
    check({tag, ".ifid_inst"}, ifid_inst, ei);
    check({tag, ".ifid_pc_plus4"}, ifid_pc_plus4, ep4);
    check({tag, ".ifid_valid"}, {31'd0, ifid_valid}, {31'd0, ev});
    check({tag, ".addr_err"}, {31'd0, addr_err}, {31'd0, eae});
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drive_idle();

    //   rst s  br off       j  idx         jr jrt           idpc4         im             e_pc          e_inst        e_p4          v  ae
    add(1, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    add(1, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h3409000A, 32'h4,        32'h3409000A, 32'h4,        1, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h11111111, 32'h8,        32'h11111111, 32'h8,        1, 0);
    add(0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h22222222, 32'h8,        32'h11111111, 32'h8,        1, 0);
    add(0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h22222222, 32'h8,        32'h11111111, 32'h8,        1, 0);
    add(0, 1, 1, 16'hFFFA, 0, 26'h0,       0, 32'h0,        32'h18,       32'h22222222, 32'h8,        32'h11111111, 32'h8,        1, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h22222222, 32'hC,        32'h22222222, 32'hC,        1, 0);
    add(0, 0, 1, 16'hFFFA, 0, 26'h0,       0, 32'h0,        32'h18,       32'h77777777, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h3409000A, 32'h4,        32'h3409000A, 32'h4,        1, 0);
    add(0, 0, 0, 16'h0,    1, 26'h0000C01, 0, 32'h0,        32'h1C,       32'h77777777, 32'h3004,     32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    1, 26'h0000C01, 1, 32'h103,      32'h1C,       32'h77777777, 32'h100,      32'h0,        32'h0,        0, 1);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h33333333, 32'h104,      32'h33333333, 32'h104,      1, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       1, 32'hFFFFFFFC, 32'h0,        32'h77777777, 32'hFFFFFFFC, 32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h44444444, 32'h0,        32'h44444444, 32'h0,        1, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       1, 32'h202,      32'h0,        32'h77777777, 32'h200,      32'h0,        32'h0,        0, 1);
    add(0, 1, 0, 16'h0,    0, 26'h0,       1, 32'h202,      32'h0,        32'h77777777, 32'h200,      32'h0,        32'h0,        0, 0);
    add(0, 0, 1, 16'h0004, 0, 26'h0,       0, 32'h0,        32'h100,      32'h77777777, 32'h110,      32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    1, 26'h3FFFFFF, 0, 32'h0,        32'hA0000000, 32'h77777777, 32'hAFFFFFFC, 32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h55555555, 32'hB0000000, 32'h55555555, 32'hB0000000, 1, 0);
    add(0, 1, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h66666666, 32'hB0000000, 32'h55555555, 32'hB0000000, 1, 0);
    add(1, 1, 0, 16'h0,    0, 26'h0,       1, 32'h103,      32'h0,        32'h66666666, 32'h0,        32'h0,        32'h0,        0, 0);
    add(0, 0, 0, 16'h0,    0, 26'h0,       0, 32'h0,        32'h0,        32'h66666666, 32'h4,        32'h66666666, 32'h4,        1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; stall = vecs[i].stall; br_taken = vecs[i].br;
      br_offset = vecs[i].off; jmp = vecs[i].jmp; jmp_index = vecs[i].idx;
      jr = vecs[i].jr; jr_target = vecs[i].jrt; id_pc_plus4 = vecs[i].idpc4;
      im_inst = vecs[i].im;
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", i), vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_p4,
                  vecs[i].e_v, vecs[i].e_ae);
    end

    // Reset release: pc_out steps 0,4,8,12 with the fetched word following one edge behind.
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("seq_pc%0d", k), pc_out, 32'(k * 4));
      im_inst = 32'hA000_0000 | 32'(k);
      @(posedge clk);
      #1;
      check($sformatf("seq_inst%0d", k), ifid_inst, 32'hA000_0000 | 32'(k));
      check($sformatf("seq_p4_%0d", k), ifid_pc_plus4, 32'((k + 1) * 4));
      @(negedge clk);
    end

    // Misaligned jr held two cycles: each redirect is honoured and flags; flag drops after.
    jr = 1'b1;
    jr_target = 32'h0000_0301;
    @(posedge clk);
    #1;
    check_state("jr_hold1", 32'h300, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    jr_target = 32'h0000_0403;
    @(posedge clk);
    #1;
    check_state("jr_hold2", 32'h400, 32'h0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    jr = 1'b0;
    im_inst = 32'h0BAD_F00D;
    @(posedge clk);
    #1;
    check_state("jr_after", 32'h404, 32'h0BAD_F00D, 32'h404, 1'b1, 1'b0);
    @(negedge clk);
    check("jr_after_hold_ae", {31'd0, addr_err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
